// File: rtl/phase1_sequencer_if.sv
// Bundle of host control, per-cell status and sequencer outputs for phase1_sequencer.
//   master : host/cell side, drives control and per-cell status, observes sequencer outputs
//   slave  : sequencer side
// Control      : ctl_ready (start level), ctl_double_buffer, cell_mask[N_CELL]
// Cell status  : done_batch, done_all, in_flight, pipe_done, v_rempty (all N_CELL wide)
// Outputs      : dispatch[1:0] (01 batch, 10 flush), buf_sel, batch_count[BATCH_W],
//                busy, ctl_done, err_limit
interface phase1_sequencer_if #(
  parameter int unsigned N_CELL  = 14,
  parameter int unsigned BATCH_W = 16
);
  logic               ctl_ready;
  logic               ctl_double_buffer;
  logic [N_CELL-1:0]  cell_mask;
  logic [N_CELL-1:0]  done_batch;
  logic [N_CELL-1:0]  done_all;
  logic [N_CELL-1:0]  in_flight;
  logic [N_CELL-1:0]  pipe_done;
  logic [N_CELL-1:0]  v_rempty;
  logic [1:0]         dispatch;
  logic               buf_sel;
  logic [BATCH_W-1:0] batch_count;
  logic               busy;
  logic               ctl_done;
  logic               err_limit;

  modport master (
    output ctl_ready, ctl_double_buffer, cell_mask,
    output done_batch, done_all, in_flight, pipe_done, v_rempty,
    input  dispatch, buf_sel, batch_count, busy, ctl_done, err_limit
  );

  modport slave (
    input  ctl_ready, ctl_double_buffer, cell_mask,
    input  done_batch, done_all, in_flight, pipe_done, v_rempty,
    output dispatch, buf_sel, batch_count, busy, ctl_done, err_limit
  );
endinterface

// File: rtl/phase1_sequencer.sv
// Phase-1 control-path sequencer.
// Reduces per-cell status (masked by cell_mask) into four registered flags, then runs a
// batch-dispatch FSM: dispatch batches until every participating cell reports done_all
// (or the batch limit is hit, raising err_limit), issue a flush, wait for a programmable
// run of quiescent cycles, then report ctl_done and optionally swap the active buffer.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : phase1_sequencer_if.slave (control, per-cell status, sequencer outputs)
module phase1_sequencer #(
  parameter int unsigned N_CELL       = 14,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned BATCH_W      = 16,
  parameter int unsigned MAX_BATCHES  = 65535
) (
  input  logic              clk,
  input  logic              reset,
  phase1_sequencer_if.slave bus
);

  localparam int unsigned DrainW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DrainW-1:0]  DrainLast = DrainW'(DRAIN_CYCLES);
  localparam logic [BATCH_W-1:0] BatchMax  = BATCH_W'(MAX_BATCHES);

  typedef enum logic [2:0] {
    StIdle,
    StDispatch,
    StSettle,
    StWaitBatch,
    StFlush,
    StDrain,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic               batch_done_q, batch_done_d;
  logic               all_done_q, all_done_d;
  logic               flight_q, flight_d;
  logic               quiet_q, quiet_d;
  logic [DrainW-1:0]  drain_q, drain_d;
  logic [BATCH_W-1:0] batch_count_q, batch_count_d;
  logic               err_limit_q, err_limit_d;
  logic               buf_sel_q, buf_sel_d;

  // Status stage: masked-out cells count as done and quiet, never in flight.
  always_comb begin
    batch_done_d = &(bus.done_batch | ~bus.cell_mask);
    all_done_d   = &(bus.done_all | ~bus.cell_mask);
    flight_d     = |(bus.in_flight & bus.cell_mask);
    quiet_d      = &((bus.pipe_done & bus.v_rempty) | ~bus.cell_mask);
  end

  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    batch_count_d = batch_count_q;
    err_limit_d   = err_limit_q;
    buf_sel_d     = buf_sel_q;

    unique case (state_q)
      StIdle: begin
        if (bus.ctl_ready) begin
          state_d       = StDispatch;
          batch_count_d = '0;
          err_limit_d   = 1'b0;
        end
      end
      StDispatch: begin
        // Saturating: never wraps back to zero.
        if (batch_count_q != '1) begin
          batch_count_d = batch_count_q + BATCH_W'(1);
        end
        state_d = StSettle;
      end
      // Gives the status stage one edge to capture the cells' reaction to the dispatch.
      StSettle: state_d = StWaitBatch;
      StWaitBatch: begin
        if (batch_done_q && !flight_q) begin
          if (all_done_q) begin
            state_d = StFlush;
          end else if (batch_count_q == BatchMax) begin
            err_limit_d = 1'b1;
            state_d     = StFlush;
          end else begin
            state_d = StDispatch;
          end
        end
      end
      StFlush: begin
        drain_d = '0;
        state_d = StDrain;
      end
      StDrain: begin
        // Any non-quiet cycle restarts the debounce window.
        if (drain_q == DrainLast) begin
          state_d = StDone;
          if (bus.ctl_double_buffer) begin
            buf_sel_d = ~buf_sel_q;
          end
        end else if (quiet_q) begin
          drain_d = drain_q + DrainW'(1);
        end else begin
          drain_d = '0;
        end
      end
      StDone: begin
        if (!bus.ctl_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.dispatch = 2'b00;
    bus.busy     = 1'b0;
    bus.ctl_done = 1'b0;
    unique case (state_q)
      StDispatch: begin
        bus.dispatch = 2'b01;
        bus.busy     = 1'b1;
      end
      StFlush: begin
        bus.dispatch = 2'b10;
        bus.busy     = 1'b1;
      end
      StSettle, StWaitBatch, StDrain: bus.busy = 1'b1;
      StDone:                         bus.ctl_done = 1'b1;
      default: ;
    endcase
  end

  assign bus.buf_sel     = buf_sel_q;
  assign bus.batch_count = batch_count_q;
  assign bus.err_limit   = err_limit_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      batch_done_q  <= 1'b0;
      all_done_q    <= 1'b0;
      flight_q      <= 1'b0;
      quiet_q       <= 1'b0;
      drain_q       <= '0;
      batch_count_q <= '0;
      err_limit_q   <= 1'b0;
      buf_sel_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      batch_done_q  <= batch_done_d;
      all_done_q    <= all_done_d;
      flight_q      <= flight_d;
      quiet_q       <= quiet_d;
      drain_q       <= drain_d;
      batch_count_q <= batch_count_d;
      err_limit_q   <= err_limit_d;
      buf_sel_q     <= buf_sel_d;
    end
  end

endmodule

// File: tb/tb_phase1_sequencer.sv
// Bench for phase1_sequencer: directed runs with a randomized cell responder, then fully
// random inputs with occasional resets, all checked every cycle against a procedural model.
module tb_phase1_sequencer;
  localparam int unsigned N    = 4;
  localparam int unsigned D    = 3;
  localparam int unsigned BW   = 4;
  localparam int unsigned MAXB = 5;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  phase1_sequencer_if #(.N_CELL(N), .BATCH_W(BW)) bus ();

  phase1_sequencer #(
    .N_CELL      (N),
    .DRAIN_CYCLES(D),
    .BATCH_W     (BW),
    .MAX_BATCHES (MAXB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Registered view of the cell reductions: what the controller decides on at each edge.
  bit sb, sa, sf, sq;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb <= 0; sa <= 0; sf <= 0; sq <= 0;
    end else begin
      bit b, a, f, q;
      b = 1; a = 1; f = 0; q = 1;
      for (int i = 0; i < N; i++) begin
        if (bus.cell_mask[i]) begin
          b = b & bus.done_batch[i];
          a = a & bus.done_all[i];
          f = f | bus.in_flight[i];
          q = q & bus.pipe_done[i] & bus.v_rempty[i];
        end
      end
      sb <= b; sa <= a; sf <= f; sq <= q;
    end
  end

  int unsigned m_cnt = 0;
  bit          m_err = 0;
  bit          m_buf = 0;
  int          exp_disp = 0;
  bit          exp_busy = 0;
  bit          exp_done = 0;

  // One clock edge; reports (and applies) a reset seen at that edge.
  task automatic tick(output bit ab);
    @(posedge clk);
    ab = !reset;
    if (ab) begin
      m_cnt = 0; m_err = 0; m_buf = 0;
      exp_disp = 0; exp_busy = 0; exp_done = 0;
    end
  endtask

  initial begin : ref_model
    bit ab, fin;
    int quiet;
    forever begin
      exp_disp = 0; exp_busy = 0; exp_done = 0;
      do tick(ab); while (ab || !bus.ctl_ready);
      m_cnt = 0; m_err = 0; fin = 0; ab = 0;
      while (!ab && !fin) begin
        exp_disp = 1; exp_busy = 1;
        tick(ab);
        if (ab) break;
        if (m_cnt < (1 << BW) - 1) m_cnt++;
        exp_disp = 0;
        tick(ab);
        if (ab) break;
        do tick(ab); while (!ab && !(sb && !sf));
        if (ab) break;
        if (sa) fin = 1;
        else if (m_cnt == MAXB) begin
          m_err = 1;
          fin   = 1;
        end
      end
      if (!ab) begin
        exp_disp = 2;
        tick(ab);
        if (!ab) begin
          exp_disp = 0;
          quiet    = 0;
          // D consecutive quiet edges, then one further edge enters DONE.
          forever begin
            tick(ab);
            if (ab || quiet == D) break;
            quiet = sq ? quiet + 1 : 0;
          end
          if (!ab) begin
            if (bus.ctl_double_buffer) m_buf = !m_buf;
            exp_busy = 0; exp_done = 1;
            do tick(ab); while (!ab && bus.ctl_ready);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("dispatch",    int'(bus.dispatch),    exp_disp);
      chk("busy",        int'(bus.busy),        int'(exp_busy));
      chk("ctl_done",    int'(bus.ctl_done),    int'(exp_done));
      chk("buf_sel",     int'(bus.buf_sel),     int'(m_buf));
      chk("batch_count", int'(bus.batch_count), int'(m_cnt));
      chk("err_limit",   int'(bus.err_limit),   int'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic chk_zero(input string tag);
    chk({tag, "_dispatch"}, int'(bus.dispatch),    0);
    chk({tag, "_busy"},     int'(bus.busy),        0);
    chk({tag, "_done"},     int'(bus.ctl_done),    0);
    chk({tag, "_buf"},      int'(bus.buf_sel),     0);
    chk({tag, "_count"},    int'(bus.batch_count), 0);
    chk({tag, "_err"},      int'(bus.err_limit),   0);
  endtask

  task automatic rand_inputs();
    bus.ctl_ready         = ($urandom_range(0, 9) < 7);
    bus.ctl_double_buffer = 1'($urandom);
    if ($urandom_range(0, 9) == 0) bus.cell_mask = N'($urandom);
    bus.done_batch = N'($urandom) | N'($urandom);
    bus.done_all   = ($urandom_range(0, 3) == 0) ? '1 : N'($urandom);
    bus.in_flight  = N'($urandom) & N'($urandom) & N'($urandom);
    bus.pipe_done  = ~(N'($urandom) & N'($urandom) & N'($urandom));
    bus.v_rempty   = ~(N'($urandom) & N'($urandom) & N'($urandom));
  endtask

  // Runs one start-to-done sequence; called and returns just after a falling edge.
  task automatic do_run(input logic [N-1:0] mask, input int rounds, input bit dbuf,
                        input bit glitch, input bit use_resp,
                        output int lat_start, output int lat_flush,
                        output int n_disp, output int n_flush);
    int pend, got, gl, cyc;
    bit seen_flush;
    pend = 0; got = 0; gl = 0; cyc = 0; seen_flush = 0;
    lat_flush = 0; n_disp = 0; n_flush = 0;
    bus.cell_mask = mask;
    bus.ctl_double_buffer = dbuf;
    bus.pipe_done = '1;
    bus.v_rempty  = '1;
    if (use_resp) begin
      bus.done_batch = '0; bus.done_all = '0; bus.in_flight = ~mask;
    end else begin
      bus.done_batch = '1; bus.done_all = '1; bus.in_flight = '0;
    end
    bus.ctl_ready = 1'b1;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (seen_flush) lat_flush++;
      if (bus.ctl_done) break;
      if (bus.dispatch == 2'b01) begin
        n_disp++;
        chk("no_dispatch_in_flight", int'((bus.in_flight & mask) != '0), 0);
      end
      #1;
      bus.v_rempty = '1;
      if (gl > 0) begin
        gl--;
        if (gl == 0) bus.v_rempty[2] = 1'b0;
      end
      if (bus.dispatch == 2'b10) begin
        n_flush++;
        seen_flush = 1'b1;
        if (glitch) gl = 2;
      end
      if (use_resp) begin
        if (bus.dispatch == 2'b01) begin
          bus.in_flight  = (N'($urandom) & mask) | ~mask;
          bus.done_batch = '0;
          bus.done_all   = '0;
          pend = $urandom_range(1, 4);
        end else if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            got++;
            bus.in_flight  = ~mask;
            bus.done_batch = mask;
            if (rounds > 0 && got >= rounds) bus.done_all = mask;
          end
        end
      end
    end
    lat_start = cyc;
    chk("run_completes", int'(bus.ctl_done), 1);
    #1;
    bus.ctl_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin : stim
    int ls, lf, nd, nf, rst_hold;
    bus.ctl_ready = 0; bus.ctl_double_buffer = 0; bus.cell_mask = '1;
    bus.done_batch = '0; bus.done_all = '0; bus.in_flight = '0;
    bus.pipe_done = '1; bus.v_rempty = '1;
    reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      rand_inputs();
      #1;
      chk_zero("in_reset");
    end
    bus.ctl_ready = 1'b0;
    bus.cell_mask = '1;
    reset = 1'b1;
    @(negedge clk);
    chk("idle_dispatch", int'(bus.dispatch), 0);
    chk("idle_busy",     int'(bus.busy),     0);
    #1;

    do_run(4'b1111, 1, 0, 0, 0, ls, lf, nd, nf);
    chk("min_run_edges",   ls, D + 6);
    chk("min_run_batches", int'(bus.batch_count), 1);

    do_run(4'b1111, 1, 0, 0, 1, ls, lf, nd, nf);
    chk("single_dispatches", nd, 1);
    chk("single_flushes",    nf, 1);
    chk("single_batches",    int'(bus.batch_count), 1);
    chk("single_drain_lat",  lf, D + 2);

    do_run(4'b1111, 3, 0, 0, 1, ls, lf, nd, nf);
    chk("multi_dispatches", nd, 3);
    chk("multi_batches",    int'(bus.batch_count), 3);

    do_run(4'b0101, 2, 0, 0, 1, ls, lf, nd, nf);
    chk("mask_batches", int'(bus.batch_count), 2);
    chk("mask_flushes", nf, 1);
    chk("mask_err",     int'(bus.err_limit), 0);

    do_run(4'b1111, 1, 1, 1, 1, ls, lf, nd, nf);
    chk("debounce_drain_lat", lf, D + 5);
    chk("dbuf_first_toggle",  int'(bus.buf_sel), 1);

    do_run(4'b1111, 1, 1, 0, 1, ls, lf, nd, nf);
    chk("dbuf_second_toggle", int'(bus.buf_sel), 0);

    do_run(4'b1111, 0, 0, 0, 1, ls, lf, nd, nf);
    chk("limit_dispatches", nd, MAXB);
    chk("limit_batches",    int'(bus.batch_count), MAXB);
    chk("limit_err",        int'(bus.err_limit), 1);
    chk("limit_flushes",    nf, 1);

    // Hold in_flight so the controller parks in WAIT_BATCH, then reset between edges.
    bus.cell_mask = '1; bus.in_flight = '1; bus.done_batch = '0; bus.done_all = '0;
    bus.ctl_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #1;
    end
    chk("wait_busy", int'(bus.busy), 1);
    reset = 1'b0;
    #1;
    chk_zero("mid_reset");
    repeat (2) begin
      @(negedge clk);
      #1;
    end
    bus.ctl_ready = 1'b0;
    reset = 1'b1;

    rst_hold = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      #1;
      rand_inputs();
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) reset = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        reset = 1'b0;
        rst_hold = 2;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
